// File: rtl/divider_pkg.sv
// divider_pkg
//   Shared constants for the sequential restoring divider:
//   - DEFAULT_WIDTH : default operand / quotient / remainder width
//   - ST_*          : FSM state encoding used by divider_8bit
package divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/divider_8bit_subtractor_borrow.sv
// subtractor_borrow
//   Combinational N-bit subtractor built as a + ~b + 1, in the same
//   carry-out style as the adder. borrow is the inverted carry out.
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  1 when b > a
module subtractor_borrow
    import divider_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign diff   = sum[N-1:0];
    assign borrow = ~sum[N];

endmodule

// File: rtl/divider_8bit.sv
// divider_8bit
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   A divide by zero finishes immediately with quotient all-ones,
//   remainder = dividend and div_by_zero set.
// Ports:
//   clk          in  1      clock, rising edge
//   rst_n        in  1      synchronous active-low reset
//   start        in  1      request, accepted in IDLE or DONE
//   dividend     in  WIDTH  sampled at acceptance
//   divisor      in  WIDTH  sampled at acceptance
//   busy         out 1      high while iterating
//   done         out 1      one-cycle result strobe
//   quotient     out WIDTH  held until next acceptance
//   remainder    out WIDTH  held until next acceptance
//   div_by_zero  out 1      qualifies the held result
module divider_8bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dq, dvs;
    logic [WIDTH:0]   rem;

    logic             accept, last_step;
    logic [WIDTH:0]   shifted, diff, rem_nxt;
    logic [WIDTH-1:0] dq_nxt;
    logic             borrow, q_bit;

    // rem[WIDTH] is never needed as an input to the next step: the
    // restored remainder is always below the divisor, so it is 0.
    logic rem_msb_unused;
    assign rem_msb_unused = rem[WIDTH];

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign last_step = (state == ST_RUN) && (cnt == CW'(1));

    // One restoring step: shift in the next dividend bit, try to subtract.
    assign shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};

    subtractor_borrow #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign q_bit   = ~borrow;
    assign rem_nxt = borrow ? shifted : diff;
    assign dq_nxt  = {dq[WIDTH-2:0], q_bit};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
                else        state_nxt = ST_IDLE;
            end
            ST_RUN:  state_nxt = last_step ? ST_DONE : ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Datapath and result holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            dq          <= '0;
            dvs         <= '0;
            rem         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                dq          <= dividend;
                dvs         <= divisor;
                rem         <= '0;
                cnt         <= CW'(WIDTH);
                div_by_zero <= 1'b0;
            end else begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == ST_RUN) begin
            dq  <= dq_nxt;
            rem <= rem_nxt;
            cnt <= cnt - CW'(1);
            // Results are captured from the final step's combinational value
            // so they are valid in the DONE cycle itself.
            if (last_step) begin
                quotient  <= dq_nxt;
                remainder <= rem_nxt[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_divider_8bit.sv
// tb_divider_8bit
//   Scoreboard bench for divider_8bit: the stimulus side pushes the
//   expected result (from plain / and %) for every accepted request, and
//   a monitor pops and compares on each done pulse.
module tb_divider_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    divider_8bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_div(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = 8'd255; e.r = 8'(a); e.dbz = 1'b1;
        end else begin
            e.q = 8'(a / b); e.r = 8'(a % b); e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("busy_low_at_done", int'(busy), 0);
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: q=%0d r=%0d with empty scoreboard", quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    int'(quotient),    int'(e.q));
                chk("remainder",   int'(remainder),   int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
            end
        end
    end

    // Called at a negedge; returns at the first negedge after acceptance.
    // Operands are scrambled afterwards to show they are not re-sampled.
    task automatic issue(input int a, input int b, input bit expect_result);
        start = 1'b1; dividend = 8'(a); divisor = 8'(b);
        if (expect_result) sb.push_back(ref_div(a, b));
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    endtask

    // lat = cycles from acceptance edge to done (1 = cycle after E0).
    task automatic wait_done(output int lat, output int bc);
        lat = 1; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within %0d cycles", lat);
        end
    endtask

    initial begin
        int lat, bc, dones;
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_q",     int'(quotient), 0);
        chk("rst_r",     int'(remainder), 0);
        chk("rst_dbz",   int'(div_by_zero), 0);
        // start asserted under reset must be ignored
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        chk("rst_over_start", int'(busy), 0);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        issue(200, 7, 1'b1);
        wait_done(lat, bc);
        chk("lat_200_7", lat, 9);
        chk("busy_cycles_200_7", bc, 8);
        @(negedge clk);

        issue(255, 1, 1'b1);   wait_done(lat, bc);
        issue(5, 9, 1'b1);     wait_done(lat, bc);
        issue(0, 13, 1'b1);    wait_done(lat, bc);
        issue(255, 255, 1'b1); wait_done(lat, bc);
        @(negedge clk);

        issue(77, 0, 1'b1);
        wait_done(lat, bc);
        chk("lat_div0", lat, 1);
        chk("busy_cycles_div0", bc, 0);
        issue(10, 3, 1'b1);
        wait_done(lat, bc);
        chk("lat_after_div0", lat, 9);
        @(negedge clk);

        // Start during RUN is ignored.
        issue(100, 3, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        // Back-to-back: issued in the DONE cycle.
        issue(50, 5, 1'b1);
        chk("b2b_busy_rises", int'(busy), 1);
        chk("b2b_done_drops", int'(done), 0);
        wait_done(lat, bc);
        chk("lat_b2b", lat, 9);
        @(negedge clk);

        // Reset at RUN cycle 5 aborts with no done.
        issue(200, 7, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q",    int'(quotient), 0);
        chk("abort_r",    int'(remainder), 0);
        chk("abort_dbz",  int'(div_by_zero), 0);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        // Random sweep, back-to-back, ~1/8 divide-by-zero.
        for (int i = 0; i < 2000; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            issue(a, b, 1'b1);
            wait_done(lat, bc);
            chk("rand_lat", lat, (b == 0) ? 1 : 9);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
